// File: rtl/mem_ctrl.sv
// Byte-serial RAM port shared by instruction fetch and the MEM stage.
// MEM has fixed priority; requests are split into 1/2/4 little-endian byte transfers.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [3:0]            mem_sel,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic                  src_mem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            n_q;
  logic [2:0]            cnt_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;
  logic [31:0]           if_rdata_q;
  logic [31:0]           mem_rdata_q;
  logic                  if_done_q;
  logic                  mem_done_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_wr_q;
  logic [7:0]            ram_dout_q;
  logic                  busy_q;

  logic [2:0]            cnt_nxt_d;
  logic [ADDR_WIDTH-1:0] addr_nxt_d;
  logic [7:0]            byte_nxt_d;
  logic [1:0]            cap_idx_d;
  logic [31:0]           buf_d;
  logic [2:0]            sel_n_d;

  // cnt_q is the index of the byte address currently on the RAM port
  always_comb begin
    cnt_nxt_d  = cnt_q + 3'd1;
    addr_nxt_d = addr_q + ADDR_WIDTH'(cnt_nxt_d);
    cap_idx_d  = cnt_q[1:0] - 2'd1;
    case (cnt_nxt_d[1:0])
      2'd0:    byte_nxt_d = wdata_q[7:0];
      2'd1:    byte_nxt_d = wdata_q[15:8];
      2'd2:    byte_nxt_d = wdata_q[23:16];
      default: byte_nxt_d = wdata_q[31:24];
    endcase
    buf_d = buf_q;
    case (cap_idx_d)
      2'd0:    buf_d[7:0]   = ram_din;
      2'd1:    buf_d[15:8]  = ram_din;
      2'd2:    buf_d[23:16] = ram_din;
      default: buf_d[31:24] = ram_din;
    endcase
    case (mem_sel)
      4'b0001: sel_n_d = 3'd1;
      4'b0011: sel_n_d = 3'd2;
      default: sel_n_d = 3'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_mem_q   <= 1'b0;
      addr_q      <= '0;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_req || if_req) begin
            src_mem_q  <= mem_req;
            addr_q     <= mem_req ? mem_addr : if_addr;
            ram_addr_q <= mem_req ? mem_addr : if_addr;
            n_q        <= mem_req ? sel_n_d : 3'd4;
            wdata_q    <= mem_wdata;
            cnt_q      <= 3'd0;
            buf_q      <= 32'd0;
            busy_q     <= 1'b1;
            if (mem_req && mem_we) begin
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_wdata[7:0];
              state_q    <= S_WR;
            end else begin
              ram_wr_q   <= 1'b0;
              state_q    <= S_RD;
            end
          end
        end
        S_RD: begin
          cnt_q <= cnt_nxt_d;
          if (cnt_q != 3'd0) begin
            buf_q <= buf_d;
          end
          if (cnt_nxt_d < n_q) begin
            ram_addr_q <= addr_nxt_d;
          end
          // Last byte arrives in C(N+1); publish it together with the done pulse
          if (cnt_q == n_q) begin
            state_q <= S_DONE;
            if (src_mem_q) begin
              mem_rdata_q <= buf_d;
              mem_done_q  <= 1'b1;
            end else begin
              if_rdata_q  <= buf_d;
              if_done_q   <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (cnt_nxt_d < n_q) begin
            cnt_q      <= cnt_nxt_d;
            ram_addr_q <= addr_nxt_d;
            ram_dout_q <= byte_nxt_d;
          end else begin
            ram_wr_q   <= 1'b0;
            mem_done_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          ram_wr_q   <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed vector bench for mem_ctrl with a behavioural byte RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [logic [31:0]];

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: read data appears the cycle after the address
  always @(posedge clk) begin
    ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
    if (ram_wr) ram[ram_addr] = ram_dout;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] pre;   // bytes preloaded at addr..addr+3
    logic [31:0] exp;   // read result, or RAM word after a store
    int          n;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ram[a + 32'(i)] = w[8*i +: 8];
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [31:0] got;
    preload(v.addr, v.pre);
    @(negedge clk);
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
      mem_sel = v.sel; mem_wdata = v.wdata;
    end
    @(posedge clk);
    for (int c = 1; c <= v.lat + 1; c++) begin
      @(negedge clk);
      if (c <= v.n) begin
        chk($sformatf("v%0d C%0d ram_addr", k, c), ram_addr, v.addr + 32'(c - 1));
        chk($sformatf("v%0d C%0d ram_wr", k, c), {31'd0, ram_wr}, {31'd0, v.we});
        if (v.we) chk($sformatf("v%0d C%0d ram_dout", k, c), {24'd0, ram_dout}, {24'd0, v.wdata[8*(c-1) +: 8]});
      end else begin
        chk($sformatf("v%0d C%0d ram_wr idle", k, c), {31'd0, ram_wr}, 32'd0);
      end
      chk($sformatf("v%0d C%0d busy", k, c), {31'd0, busy}, {31'd0, c <= v.lat});
      chk($sformatf("v%0d C%0d if_done", k, c), {31'd0, if_done}, {31'd0, v.is_if && c == v.lat});
      chk($sformatf("v%0d C%0d mem_done", k, c), {31'd0, mem_done}, {31'd0, !v.is_if && c == v.lat});
      if (c == v.lat) begin
        if (!v.we) chk($sformatf("v%0d rdata", k), v.is_if ? if_rdata : mem_rdata, v.exp);
        if_req = 1'b0; mem_req = 1'b0;
      end
    end
    if (v.we) begin
      for (int i = 0; i < 4; i++) got[8*i +: 8] = ram[v.addr + 32'(i)];
      chk($sformatf("v%0d ram contents", k), got, v.exp);
    end
  endtask

  initial begin
    //        is_if we    addr           sel      wdata          pre            exp            n  lat
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_0513, 32'h0000_0513, 4, 6};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_1000, 4'b1111, 32'h1122_3344, 32'h0,         32'h1122_3344, 4, 5};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_3000, 4'b0011, 32'hABCD_1234, 32'h7766_5544, 32'h7766_1234, 2, 3};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 4'b1111, 32'h0,         32'hDDCC_BBAA, 32'hDDCC_BBAA, 4, 6};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_2000, 4'b0011, 32'h0,         32'h0055_CAFE, 32'h0000_CAFE, 2, 4};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_4000, 4'b0101, 32'h0,         32'h0403_0201, 32'h0403_0201, 4, 6};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_5000, 4'b0001, 32'hFFFF_FFA5, 32'h9988_7766, 32'h9988_77A5, 1, 2};

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = 32'h0; mem_sel = 4'b0000; mem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("reset ram_addr", ram_addr, 32'd0);
    chk("reset rdata", if_rdata | mem_rdata, 32'd0);
    chk("reset done", {30'd0, if_done, mem_done}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Contention: MEM LB wins, IF follows after one IDLE cycle
    preload(32'h0000_0100, 32'h0000_0513);
    ram[32'h0000_2003] = 8'h80;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_2003; mem_sel = 4'b0001;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("cont C%0d mem_done", c), {31'd0, mem_done}, {31'd0, c == 3});
      chk($sformatf("cont C%0d if_done", c), {31'd0, if_done}, {31'd0, c == 10});
      chk($sformatf("cont C%0d ram_wr", c), {31'd0, ram_wr}, 32'd0);
      if (c == 1) chk("cont mem addr", ram_addr, 32'h0000_2003);
      if (c == 3) begin
        chk("cont mem_rdata", mem_rdata, 32'h0000_0080);
        mem_req = 1'b0;
      end
      if (c == 4) chk("cont C4 busy", {31'd0, busy}, 32'd0);
      if (c >= 5 && c <= 8) chk($sformatf("cont C%0d if addr", c), ram_addr, 32'h0000_0100 + 32'(c - 5));
      if (c == 10) begin
        chk("cont if_rdata", if_rdata, 32'h0000_0513);
        if_req = 1'b0;
      end
    end

    // Reset in C3 of an IF read, then a clean read
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_4000;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst C%0d if_done", c), {31'd0, if_done}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst busy", {31'd0, busy}, 32'd0);
    chk("mid-rst ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("mid-rst ram_addr", ram_addr, 32'd0);
    chk("mid-rst if_done", {31'd0, if_done}, 32'd0);
    chk("mid-rst rdata", if_rdata | mem_rdata, 32'd0);
    rst = 1'b0; if_addr = 32'h0000_0100;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst C%0d if_done", c), {31'd0, if_done}, {31'd0, c == 6});
      if (c <= 4) chk($sformatf("post-rst C%0d addr", c), ram_addr, 32'h0000_0100 + 32'(c - 1));
      if (c == 6) begin
        chk("post-rst if_rdata", if_rdata, 32'h0000_0513);
        if_req = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
